// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data memory between the pipeline MEM stage (core port)
// and a debug/loader port (dbg port).
//
// The core has default priority. A starvation counter forces a pending debug
// request through after it has lost STARVE_MAX consecutive cycles. Memory read
// data arrives one cycle after the strobe, so the owner of each read is
// registered and the returning data is steered to that requester.
//
// Optional build macro: DMEM_ARB_HALT_EN adds input dbg_halt. While it is high
// the core is never granted, and debug wins whenever it has an eligible request.
//
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   core_*           MEM stage request in; core_stall, core_rvalid, core_rdata out
//   dbg_*            debug request in (held until dbg_ack); dbg_ack, dbg_rdata out
//   mem_*            memory strobe/address/data/mask out; mem_rdata in (1-cycle latency)
//   dbg_halt         (DMEM_ARB_HALT_EN only) freeze core, debug owns the memory
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef DMEM_ARB_HALT_EN
    input  logic                dbg_halt,
`endif
    input  logic                core_req,
    input  logic                core_we,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    input  logic [DATA_W/8-1:0] core_mask,
    output logic                core_stall,
    output logic                core_rvalid,
    output logic [DATA_W-1:0]   core_rdata,
    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    output logic                dbg_ack,
    output logic [DATA_W-1:0]   dbg_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_mask,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    // Doubles as the winner encoding and the read-owner encoding.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } own_t;

    own_t              win;
    own_t              rd_own, rd_own_nxt;
    logic              dbg_busy, dbg_busy_nxt;
    logic              ack_pend, ack_pend_nxt;
    logic [3:0]        starve_cnt, starve_nxt;
    logic [DATA_W-1:0] core_rdata_q, dbg_rdata_q;
    logic              halt;
    logic              dbg_elig;
    logic              starved;

`ifdef DMEM_ARB_HALT_EN
    assign halt = dbg_halt;
`else
    assign halt = 1'b0;
`endif

    // dbg_busy blocks a still-high dbg_req from issuing again before its ack.
    assign dbg_elig = dbg_req && !dbg_busy;
    assign starved  = (starve_cnt == 4'(STARVE_MAX));

    // Grant. Nothing is granted while reset is held so no access leaks out.
    always_comb begin
        win = OWN_NONE;
        if (rst) begin
            win = OWN_NONE;
        end else if (halt) begin
            if (dbg_elig) win = OWN_DBG;
        end else if (dbg_elig && starved) begin
            win = OWN_DBG;
        end else if (core_req) begin
            win = OWN_CORE;
        end else if (dbg_elig) begin
            win = OWN_DBG;
        end
    end

    // Memory mux. Debug accesses are always full-word.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_mask  = core_mask;
        if (win == OWN_CORE) begin
            mem_en = 1'b1;
            mem_we = core_we;
        end else if (win == OWN_DBG) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_mask  = {MASK_W{1'b1}};
        end
    end

    assign core_stall = core_req && (win != OWN_CORE);

    // Next-state for the tracking registers.
    always_comb begin
        rd_own_nxt   = OWN_NONE;
        ack_pend_nxt = (win == OWN_DBG);
        dbg_busy_nxt = dbg_busy;
        starve_nxt   = starve_cnt;

        if (win == OWN_CORE && !core_we) rd_own_nxt = OWN_CORE;
        if (win == OWN_DBG  && !dbg_we)  rd_own_nxt = OWN_DBG;

        if (win == OWN_DBG)  dbg_busy_nxt = 1'b1;
        else if (dbg_ack)    dbg_busy_nxt = 1'b0;

        if (halt || !dbg_req || win == OWN_DBG)
            starve_nxt = 4'd0;
        else if (!dbg_busy && starve_cnt < 4'(STARVE_MAX))
            starve_nxt = starve_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_own       <= OWN_NONE;
            ack_pend     <= 1'b0;
            dbg_busy     <= 1'b0;
            starve_cnt   <= 4'd0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            rd_own     <= rd_own_nxt;
            ack_pend   <= ack_pend_nxt;
            dbg_busy   <= dbg_busy_nxt;
            starve_cnt <= starve_nxt;
            // Keep the last returned word so rdata holds between returns
            // (debug writes ack with the previous read value).
            if (rd_own == OWN_CORE) core_rdata_q <= mem_rdata;
            if (rd_own == OWN_DBG)  dbg_rdata_q  <= mem_rdata;
        end
    end

    // Returns are decoded from registered owner state; memory data arrives in
    // this same cycle, so it is forwarded straight through. A reset in the
    // return cycle discards the return.
    assign core_rvalid = (rd_own == OWN_CORE) && !rst;
    assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
    assign dbg_ack     = ack_pend && !rst;
    assign dbg_rdata   = ((rd_own == OWN_DBG) && !rst) ? mem_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed stimulus, expected returns pushed into
// per-port queues and checked by an independent negedge monitor.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_halt;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata;
    logic [3:0]  core_mask;
    logic        core_stall, core_rvalid;
    logic [31:0] core_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
`ifdef DMEM_ARB_HALT_EN
        .dbg_halt(dbg_halt),
`endif
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_mask(core_mask), .core_stall(core_stall),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: 16 words, 1-cycle read latency, byte-masked writes.
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[5:2]];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cy;
        logic [31:0] d;
    } exp_t;
    exp_t core_q[$];
    exp_t dbg_q[$];

    int compared = 0;
    int mismatched = 0;
    logic [31:0] dbg_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_core(input logic [31:0] d);
        core_q.push_back('{cy: cyc + 1, d: d});
    endtask

    task automatic exp_dbg(input logic [31:0] d);
        dbg_q.push_back('{cy: cyc + 1, d: d});
    endtask

    // Monitor: every return must match the head of its queue in cycle and data.
    always @(negedge clk) begin
        exp_t e;
        if (core_rvalid) begin
            if (core_q.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL core_unexpected: got rvalid rdata %h expected none (cycle %0d)", core_rdata, cyc);
            end else begin
                e = core_q.pop_front();
                chk("core_ret_cycle", cyc, e.cy);
                chk("core_rdata", core_rdata, e.d);
            end
        end
        if (dbg_ack) begin
            if (dbg_q.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL dbg_unexpected: got ack rdata %h expected none (cycle %0d)", dbg_rdata, cyc);
            end else begin
                e = dbg_q.pop_front();
                chk("dbg_ack_cycle", cyc, e.cy);
                chk("dbg_rdata", dbg_rdata, e.d);
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge, return at the
    // following falling edge so the caller can check combinational outputs.
    task automatic drive(input logic r, input logic creq, input logic cwe,
                         input logic [31:0] caddr, input logic [31:0] cwd,
                         input logic [3:0] cm, input logic dreq, input logic dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd,
                         input logic h);
        @(posedge clk);
        #1;
        rst = r; core_req = creq; core_we = cwe; core_addr = caddr;
        core_wdata = cwd; core_mask = cm; dbg_req = dreq; dbg_we = dwe;
        dbg_addr = daddr; dbg_wdata = dwd; dbg_halt = h;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic core_rd(input logic [31:0] a, input logic dreq, input logic [31:0] daddr);
        drive(1'b0, 1'b1, 1'b0, a, 32'h0, 4'hF, dreq, 1'b0, daddr, 32'h0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'h1111_1111;
        mem[2] = 32'hDEAD_BEEF;
        mem[3] = 32'h3333_3333;
        mem[4] = 32'h4444_4444;
        mem_rdata = 32'h0;
        dbg_last = 32'h0;
        rst = 1'b1; core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        core_mask = 0; dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        dbg_halt = 0;

        // Reset then idle
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rst_mem_en", mem_en, 0);
        idle();
        chk("idle_rvalid", core_rvalid, 0);
        chk("idle_ack", dbg_ack, 0);
        chk("idle_core_rdata", core_rdata, 0);
        chk("idle_dbg_rdata", dbg_rdata, 0);
        chk("idle_mem_en", mem_en, 0);
        chk("idle_stall", core_stall, 0);

        // Core load 0x8
        core_rd(32'h8, 1'b0, 32'h0);
        chk("ld_mem_en", mem_en, 1);
        chk("ld_mem_we", mem_we, 0);
        chk("ld_mem_addr", mem_addr, 32'h8);
        chk("ld_stall", core_stall, 0);
        exp_core(32'hDEAD_BEEF);
        idle();

        // Debug write 0x55 to 0x0, request held through the ack cycle
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 32'h55, 1'b0);
        chk("dw_mem_en", mem_en, 1);
        chk("dw_mem_we", mem_we, 1);
        chk("dw_mem_wdata", mem_wdata, 32'h55);
        chk("dw_mem_mask", mem_mask, 32'hF);
        exp_dbg(dbg_last);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 32'h55, 1'b0);
        chk("dw_no_reissue", mem_en, 0);
        core_rd(32'h0, 1'b0, 32'h0);
        exp_core(32'h55);
        idle();

        // Starvation: core always requesting, dbg read of 0x0 wins at i==4
        for (int i = 0; i < 7; i++) begin
            core_rd(32'h8, (i <= 5), 32'h0);
            chk("starve_stall", core_stall, (i == 4));
            chk("starve_addr", mem_addr, (i == 4) ? 32'h0 : 32'h8);
            if (i == 4) begin exp_dbg(32'h55); dbg_last = 32'h55; end
            else exp_core(32'hDEAD_BEEF);
        end
        idle();

        // Masked core store then reload
        drive(1'b0, 1'b1, 1'b1, 32'h4, 32'hAAAA_BBBB, 4'h3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_mask", mem_mask, 32'h3);
        core_rd(32'h4, 1'b0, 32'h0);
        exp_core(32'h1111_BBBB);

        // Alternating core / dbg reads
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'hC, 32'h0, 1'b0);
        chk("alt_dbg_addr", mem_addr, 32'hC);
        exp_dbg(32'h3333_3333); dbg_last = 32'h3333_3333;
        core_rd(32'h10, 1'b1, 32'hC);
        chk("alt_busy_stall", core_stall, 0);
        chk("alt_core_addr", mem_addr, 32'h10);
        exp_core(32'h4444_4444);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        chk("alt_dbg2_en", mem_en, 1);
        exp_dbg(32'hDEAD_BEEF); dbg_last = 32'hDEAD_BEEF;
        core_rd(32'h0, 1'b1, 32'h8);
        exp_core(32'h55);
        idle();

        // Abandoned dbg request clears the starvation count
        for (int i = 0; i < 10; i++) begin
            core_rd(32'h8, (i < 2) || (i >= 3 && i <= 8), 32'h4);
            chk("abandon_stall", core_stall, (i == 7));
            if (i == 7) begin exp_dbg(32'h1111_BBBB); dbg_last = 32'h1111_BBBB; end
            else exp_core(32'hDEAD_BEEF);
        end
        idle();

        // Reset in the return cycle of a core read, with dbg partly starved
        core_rd(32'h8, 1'b1, 32'h0);
        exp_core(32'hDEAD_BEEF);
        core_rd(32'h8, 1'b1, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rstmid_rvalid", core_rvalid, 0);
        chk("rstmid_mem_en", mem_en, 0);
        dbg_last = 32'h0;
        for (int i = 0; i < 6; i++) begin
            core_rd(32'h8, (i <= 5), 32'h0);
            if (i == 0) chk("rstmid_dbg_rdata", dbg_rdata, 0);
            chk("rstmid_stall", core_stall, (i == 4));
            if (i == 4) begin exp_dbg(32'h55); dbg_last = 32'h55; end
            else exp_core(32'hDEAD_BEEF);
        end
        idle();

`ifdef DMEM_ARB_HALT_EN
        // Halt: core frozen, debug write then read complete
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, (i < 4), (i < 2),
                  32'h10, 32'h77, 1'b1);
            chk("halt_stall", core_stall, 1);
            chk("halt_mem_en", mem_en, (i == 0 || i == 2));
            if (i == 0) exp_dbg(dbg_last);
            if (i == 2) begin exp_dbg(32'h77); dbg_last = 32'h77; end
        end
        idle();
`endif

        idle();
        idle();
        chk("core_q_drained", core_q.size(), 0);
        chk("dbg_q_drained", dbg_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
